// File: rtl/controle_jogo_param.sv
// Purpose : control unit for the memory-sequence game; owns address, round and interval timer.
// Latency : Moore FSM with registered outputs; jogada_feita -> REGISTRA -> COMPARA -> next state on 3rd edge.
// Backpres: none; the player pulse is consumed only in ESPERA / NOVA_JOGADA, ignored elsewhere.
// Ports   : clock, reset (sync, active-high); iniciar, jogada_feita, jogada_correta, modo,
//           nivel_rodadas, nivel_tempo in; endereco/rodada address outputs; registraR, gravaM,
//           zeraR strobes; leds_mem, leds_jog, vez_jogador, nova_jogada, ganhou, perdeu,
//           timeout, pronto flags; db_estado = current state code.
module controle_jogo_param #(
   parameter int ADDR_W         = 4,
   parameter int ROUNDS_MAX     = 16,
   parameter int SHOW_CYCLES    = 1000,
   parameter int GAP_CYCLES     = 500,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              jogada_feita,
   input  logic              jogada_correta,
   input  logic              modo,
   input  logic              nivel_rodadas,
   input  logic              nivel_tempo,
   output logic [ADDR_W-1:0] endereco,
   output logic [ADDR_W-1:0] rodada,
   output logic              registraR,
   output logic              gravaM,
   output logic              zeraR,
   output logic              leds_mem,
   output logic              leds_jog,
   output logic              vez_jogador,
   output logic              nova_jogada,
   output logic              ganhou,
   output logic              perdeu,
   output logic              timeout,
   output logic              pronto,
   output logic [4:0]        db_estado
);

   localparam int MAX_SG = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
   localparam int MAX_C  = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
   localparam int TMR_W  = $clog2(MAX_C + 1);

   // Timer values on the last cycle of each timed visit.
   localparam logic [TMR_W-1:0] SHOW_END   = TMR_W'(SHOW_CYCLES - 1);
   localparam logic [TMR_W-1:0] GAP_END    = TMR_W'(GAP_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMO_END    = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMO_H_END  = TMR_W'(TIMEOUT_CYCLES / 2 - 1);
   localparam logic [ADDR_W-1:0] LAST_LONG  = ADDR_W'(ROUNDS_MAX - 1);
   localparam logic [ADDR_W-1:0] LAST_SHORT = ADDR_W'(ROUNDS_MAX / 2 - 1);

   typedef enum logic [4:0] {
      S_INICIAL     = 5'h00,
      S_PREPARA     = 5'h01,
      S_MOSTRA      = 5'h02,
      S_INTERVALO   = 5'h03,
      S_INICIO_JOG  = 5'h04,
      S_ESPERA      = 5'h05,
      S_REGISTRA    = 5'h06,
      S_COMPARA     = 5'h07,
      S_PROXIMA     = 5'h08,
      S_NOVA_JOGADA = 5'h09,
      S_GRAVA       = 5'h0A,
      S_PROX_RODADA = 5'h0B,
      S_PAUSA       = 5'h0C,
      S_GANHOU      = 5'h0D,
      S_PERDEU      = 5'h0E,
      S_TIMEOUT     = 5'h0F
   } estado_t;

   estado_t             state_q, state_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [ADDR_W-1:0]   endereco_q, endereco_d;
   logic [ADDR_W-1:0]   rodada_q, rodada_d;
   logic                modo_q, modo_d;
   logic                nivel_rod_q, nivel_rod_d;
   logic                nivel_tmp_q, nivel_tmp_d;

   logic registraR_q, registraR_d, gravaM_q, gravaM_d, zeraR_q, zeraR_d;
   logic leds_mem_q, leds_mem_d, leds_jog_q, leds_jog_d;
   logic vez_q, vez_d, nova_q, nova_d;
   logic ganhou_q, ganhou_d, perdeu_q, perdeu_d, timeout_q, timeout_d, pronto_q, pronto_d;

   logic [ADDR_W-1:0] last;
   logic [TMR_W-1:0]  lim_end;
   logic              timed;

   always_comb begin
      last    = nivel_rod_q ? LAST_LONG : LAST_SHORT;
      lim_end = nivel_tmp_q ? TMO_H_END : TMO_END;
   end

   always_comb begin
      state_d     = state_q;
      endereco_d  = endereco_q;
      rodada_d    = rodada_q;
      modo_d      = modo_q;
      nivel_rod_d = nivel_rod_q;
      nivel_tmp_d = nivel_tmp_q;

      case (state_q)
         S_INICIAL:     if (iniciar) state_d = S_PREPARA;
         S_PREPARA: begin
            modo_d      = modo;
            nivel_rod_d = nivel_rodadas;
            nivel_tmp_d = nivel_tempo;
            state_d     = S_MOSTRA;
         end
         S_MOSTRA:
            if (timer_q == SHOW_END)
               state_d = (endereco_q == rodada_q) ? S_INICIO_JOG : S_INTERVALO;
         S_INTERVALO:
            if (timer_q == GAP_END) begin
               endereco_d = endereco_q + ADDR_W'(1);
               state_d    = S_MOSTRA;
            end
         S_INICIO_JOG:  state_d = S_ESPERA;
         // The pulse takes priority over a timeout landing on the same cycle.
         S_ESPERA:
            if (jogada_feita)            state_d = S_REGISTRA;
            else if (timer_q == lim_end) state_d = S_TIMEOUT;
         S_REGISTRA:    state_d = S_COMPARA;
         S_COMPARA:
            if (!jogada_correta)             state_d = S_PERDEU;
            else if (endereco_q < rodada_q)  state_d = S_PROXIMA;
            else if (rodada_q == last)       state_d = S_GANHOU;
            else if (modo_q)                 state_d = S_NOVA_JOGADA;
            else                             state_d = S_PROX_RODADA;
         S_PROXIMA:     state_d = S_ESPERA;
         S_NOVA_JOGADA:
            if (jogada_feita)            state_d = S_GRAVA;
            else if (timer_q == lim_end) state_d = S_TIMEOUT;
         S_GRAVA:       state_d = S_PROX_RODADA;
         S_PROX_RODADA: state_d = S_PAUSA;
         S_PAUSA:       if (timer_q == GAP_END) state_d = S_MOSTRA;
         S_GANHOU, S_PERDEU, S_TIMEOUT:
            if (iniciar) state_d = S_PREPARA;
         default:       state_d = S_INICIAL;
      endcase

      // Entry actions: counters take their new value on the edge that enters the state,
      // so the state's outputs already show the updated address/round.
      if (state_d != state_q) begin
         case (state_d)
            S_PREPARA: begin
               endereco_d = '0;
               rodada_d   = '0;
            end
            S_INICIO_JOG:  endereco_d = '0;
            S_PROXIMA:     endereco_d = endereco_q + ADDR_W'(1);
            S_NOVA_JOGADA: endereco_d = rodada_q + ADDR_W'(1);
            S_PROX_RODADA: begin
               rodada_d   = rodada_q + ADDR_W'(1);
               endereco_d = '0;
            end
            default: ;
         endcase
      end
   end

   // Timer restarts from zero on every state change, counts only in timed states.
   always_comb begin
      timed = (state_q == S_MOSTRA) || (state_q == S_INTERVALO) || (state_q == S_PAUSA) ||
              (state_q == S_ESPERA) || (state_q == S_NOVA_JOGADA);
      if (state_d != state_q) timer_d = '0;
      else if (timed)         timer_d = timer_q + TMR_W'(1);
      else                    timer_d = timer_q;
   end

   // Outputs are decoded from the next state and registered, keeping them glitch-free.
   always_comb begin
      zeraR_d     = (state_d == S_INICIAL);
      registraR_d = (state_d == S_REGISTRA);
      gravaM_d    = (state_d == S_GRAVA);
      leds_mem_d  = (state_d == S_MOSTRA);
      leds_jog_d  = (state_d == S_COMPARA);
      vez_d       = (state_d == S_ESPERA) || (state_d == S_NOVA_JOGADA);
      nova_d      = (state_d == S_NOVA_JOGADA);
      ganhou_d    = (state_d == S_GANHOU);
      perdeu_d    = (state_d == S_PERDEU) || (state_d == S_TIMEOUT);
      timeout_d   = (state_d == S_TIMEOUT);
      pronto_d    = (state_d == S_GANHOU) || (state_d == S_PERDEU) || (state_d == S_TIMEOUT);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_INICIAL;
         timer_q     <= '0;
         endereco_q  <= '0;
         rodada_q    <= '0;
         modo_q      <= 1'b0;
         nivel_rod_q <= 1'b0;
         nivel_tmp_q <= 1'b0;
         zeraR_q     <= 1'b1;
         registraR_q <= 1'b0;
         gravaM_q    <= 1'b0;
         leds_mem_q  <= 1'b0;
         leds_jog_q  <= 1'b0;
         vez_q       <= 1'b0;
         nova_q      <= 1'b0;
         ganhou_q    <= 1'b0;
         perdeu_q    <= 1'b0;
         timeout_q   <= 1'b0;
         pronto_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         endereco_q  <= endereco_d;
         rodada_q    <= rodada_d;
         modo_q      <= modo_d;
         nivel_rod_q <= nivel_rod_d;
         nivel_tmp_q <= nivel_tmp_d;
         zeraR_q     <= zeraR_d;
         registraR_q <= registraR_d;
         gravaM_q    <= gravaM_d;
         leds_mem_q  <= leds_mem_d;
         leds_jog_q  <= leds_jog_d;
         vez_q       <= vez_d;
         nova_q      <= nova_d;
         ganhou_q    <= ganhou_d;
         perdeu_q    <= perdeu_d;
         timeout_q   <= timeout_d;
         pronto_q    <= pronto_d;
      end
   end

   assign endereco    = endereco_q;
   assign rodada      = rodada_q;
   assign zeraR       = zeraR_q;
   assign registraR   = registraR_q;
   assign gravaM      = gravaM_q;
   assign leds_mem    = leds_mem_q;
   assign leds_jog    = leds_jog_q;
   assign vez_jogador = vez_q;
   assign nova_jogada = nova_q;
   assign ganhou      = ganhou_q;
   assign perdeu      = perdeu_q;
   assign timeout     = timeout_q;
   assign pronto      = pronto_q;
   assign db_estado   = state_q;

endmodule

// File: doc/controle_jogo_param.md
# controle_jogo_param

Parametrised control unit for the memory-sequence game. It owns the address counter, the round counter and a single interval timer, so it no longer depends on external counter end flags. It supports a configurable round count and configurable display, pause and timeout durations. It adds a "player extends the sequence" mode that writes a new memory entry each round. It sits between the datapath (sequence memory, jogada register, comparator) and the board I/O, and drives memory addressing and control strobes directly.

## Interface
Parameters:
- ADDR_W, 4: width of `endereco`/`rodada`; requires ROUNDS_MAX ≤ 2**ADDR_W.
- ROUNDS_MAX, 16: rounds in long game; even, ≥ 2.
- SHOW_CYCLES, 1000: cycles a memory entry is displayed (≥ 1).
- GAP_CYCLES, 500: cycles of dark pause between entries and before a new round (≥ 1).
- TIMEOUT_CYCLES, 5000: player response limit in long-time level (≥ 2).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; forces INICIAL and all outputs to reset values on the next edge.
- iniciar  in  1  level; starts or restarts a game.
- jogada_feita  in  1  one-cycle pulse from the edge detector.
- jogada_correta  in  1  comparator result (registered jogada vs memory[endereco]).
- modo  in  1  0 = fixed sequence, 1 = player appends a new entry per round.
- nivel_rodadas  in  1  0 = ROUNDS_MAX/2 rounds, 1 = ROUNDS_MAX rounds.
- nivel_tempo  in  1  0 = TIMEOUT_CYCLES, 1 = TIMEOUT_CYCLES/2.
- endereco  out  ADDR_W  memory address; reset 0.
- rodada  out  ADDR_W  current round index (0-based); reset 0.
- registraR, gravaM, zeraR  out  1  datapath strobes; reset 0, except zeraR = 1 in INICIAL.
- leds_mem, leds_jog, vez_jogador, nova_jogada  out  1  display/status; reset 0.
- ganhou, perdeu, timeout, pronto  out  1  result flags; reset 0.
- db_estado  out  5  current state code; reset 5'h00.

## Operation
- Moore FSM. Every output is a function of state, `endereco` or `rodada`. No outputs are combinational from inputs.
- Internal timer: zeroed on entry to every timed state, then increments once per cycle while in that state.
- Mode and level inputs are latched in PREPARA and ignored for the rest of the game.
- `last` = (latched nivel_rodadas ? ROUNDS_MAX : ROUNDS_MAX/2) − 1. `limite` = (latched nivel_tempo ? TIMEOUT_CYCLES/2 : TIMEOUT_CYCLES).

States and codes:
- INICIAL 00: `zeraR`. Goes to PREPARA if `iniciar`.
- PREPARA 01: clears `endereco` and `rodada`, latches the mode and level inputs. Goes to MOSTRA.
- MOSTRA 02: `leds_mem`. After SHOW_CYCLES cycles, goes to INICIO_JOGADA if `endereco` == `rodada`, else to INTERVALO.
- INTERVALO 03: dark pause. After GAP_CYCLES cycles, `endereco`+1 and goes to MOSTRA.
- INICIO_JOGADA 04: clears `endereco`. Goes to ESPERA.
- ESPERA 05: `vez_jogador`.
  - On `jogada_feita`, goes to REGISTRA.
  - Otherwise, when the timer reaches `limite`, goes to TIMEOUT.
  - `jogada_feita` wins when both occur in the same cycle.
- REGISTRA 06: `registraR`. Goes to COMPARA.
- COMPARA 07: `leds_jog`, exactly 1 cycle.
  - Wrong jogada: PERDEU.
  - Correct and `endereco` < `rodada`: PROXIMA.
  - Correct, `endereco` == `rodada` and `rodada` == `last`: GANHOU.
  - Correct, `endereco` == `rodada`, below `last`, modo 0: PROX_RODADA.
  - Correct, `endereco` == `rodada`, below `last`, modo 1: NOVA_JOGADA.
- PROXIMA 08: `endereco`+1. Goes to ESPERA with the timer re-zeroed.
- NOVA_JOGADA 09: `nova_jogada` and `vez_jogador`; `endereco` = `rodada`+1, set on entry.
  - On `jogada_feita`, goes to GRAVA.
  - Otherwise the same `limite` timeout applies and goes to TIMEOUT.
- GRAVA 0A: `gravaM` for 1 cycle at `endereco` = `rodada`+1. Goes to PROX_RODADA.
- PROX_RODADA 0B: `rodada`+1, clears `endereco`. Goes to PAUSA.
- PAUSA 0C: after GAP_CYCLES cycles, goes to MOSTRA.
- GANHOU 0D: `ganhou`, `pronto`.
- PERDEU 0E: `perdeu`, `pronto`.
- TIMEOUT 0F: `perdeu`, `timeout`, `pronto`.
- From GANHOU, PERDEU and TIMEOUT, `iniciar` goes to PREPARA; otherwise they hold.
- Codes 10–1F are unused and go to INICIAL.

Width rules:
- `endereco` and `rodada` never exceed `last` + 1, so they never wrap.
- Timer width is $clog2 of max(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1.

## Timing
- Reset is sampled on `clock` edges only. It takes priority over every transition, including a reset mid-display or mid-write, where `gravaM` must drop on that edge.
- Each MOSTRA, INTERVALO and PAUSA visit lasts exactly its parameter count of cycles.
- ESPERA timeout:
  - Entered at cycle t; TIMEOUT is reached at cycle t + `limite` if no pulse arrives.
  - A pulse at cycle t + `limite` − 1 goes to REGISTRA.
- From `jogada_feita` to the result is 2 cycles: REGISTRA, then COMPARA. The next state follows on the 3rd edge.
- `iniciar` held high in INICIAL or a terminal state is consumed once. PREPARA always follows.

## Test plan
Bench parameters: ADDR_W=3, ROUNDS_MAX=4, SHOW=4, GAP=2, TIMEOUT=10.
- Reset while `db_estado`=02 → next edge `db_estado`=00; `endereco`, `rodada` and all flags are 0; `zeraR`=1.
- modo 0, nivel_rodadas 0, correct plays:
  - Round 0 shows `endereco` 0 for 4 cycles.
  - Round 1 shows 0, then a 2-cycle gap, then 1.
  - After the 2nd correct entry of round 1, `ganhou`=`pronto`=1 and `db_estado`=0D.
- Wrong play in round 0 → `perdeu`=1, `timeout`=0, state 0E. `iniciar` → PREPARA, then `rodada`=0.
- No press in ESPERA, nivel_tempo 1 → TIMEOUT after exactly 5 cycles with `timeout`=1. Repeat with a pulse at cycle 4 → REGISTRA.
- modo 1, correct play in round 0:
  - NOVA_JOGADA with `nova_jogada`=1 and `endereco`=1.
  - A pulse gives `gravaM`=1 for one cycle at `endereco` 1, then `rodada`=1.
  - Next display shows addresses 0 and 1.
- nivel_rodadas 1: full correct play → `ganhou` only after `rodada`=3 completes. Changing nivel_rodadas mid-game has no effect.
